// File: rtl/mem_arb_pkg.sv
// Shared encodings and helpers for the unified IF/MEM memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  // Latency counter must hold MEM_LAT-1; never narrower than one bit.
  function automatic int cnt_width(input int lat);
    int w;
    w = $clog2(lat + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/unified_mem_arbiter.sv
// Arbitrates one fixed-latency memory port between fetch (IF) and the MEM stage,
// alternating on contention and returning a one-cycle ready pulse to the owner.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int            CW       = cnt_width(MEM_LAT);
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LAT - 1);

  state_t        state, state_nxt;
  owner_t        owner, last_owner, grant;
  logic          grant_vld;
  logic [CW-1:0] cnt;

  assign if_stall = if_req & ~if_ready;
  assign dm_stall = dm_req & ~dm_ready;

  // Tie goes to whoever did not own the port last.
  always_comb begin
    grant_vld = if_req | dm_req;
    grant     = OWN_IF;
    if (if_req && dm_req)
      grant = (last_owner == OWN_IF) ? OWN_DM : OWN_IF;
    else if (dm_req)
      grant = OWN_DM;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = ISSUE;
      ISSUE:   state_nxt = mem_we ? RESP : WAIT;
      WAIT:    if (cnt == '0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // mem_* double as the request latch: loaded at grant, held afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= OWN_IF;
      last_owner <= OWN_DM;
      cnt        <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_ready   <= 1'b0;
      dm_ready   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_vld) begin
            owner  <= grant;
            mem_en <= 1'b1;
            if (grant == OWN_DM) begin
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
            end
          end
        end
        ISSUE: begin
          mem_en     <= 1'b0;
          mem_we     <= 1'b0;
          last_owner <= owner;
          cnt        <= CNT_INIT;
          if (mem_we) begin
            if (owner == OWN_DM) dm_ready <= 1'b1;
            else                 if_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (owner == OWN_DM) begin
            dm_rdata <= mem_rdata;
            dm_ready <= 1'b1;
          end else begin
            if_rdata <= mem_rdata;
            if_ready <= 1'b1;
          end
        end
        RESP: begin
          if_ready <= 1'b0;
          dm_ready <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: one DUT at MEM_LAT=2 plus MEM_LAT=1/4 copies for the latency sweep.
module tb_unified_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;

  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        if_ready, if_stall, dm_ready, dm_stall, mem_en, mem_we;
  logic [31:0] if_rdata_1, dm_rdata_1, mem_addr_1, mem_wdata_1, mem_rdata_1;
  logic        if_ready_1, if_stall_1, dm_ready_1, dm_stall_1, mem_en_1, mem_we_1;
  logic [31:0] if_rdata_4, dm_rdata_4, mem_addr_4, mem_wdata_4, mem_rdata_4;
  logic        if_ready_4, if_stall_4, dm_ready_4, dm_stall_4, mem_en_4, mem_we_4;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] memval(input logic [31:0] a);
    if (a == 32'h4) return 32'h0050_0113;
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory models: read data appears exactly MEM_LAT cycles after the mem_en cycle, 0 otherwise.
  logic [31:0] p2 [2];
  logic [31:0] p1 [1];
  logic [31:0] p4 [4];
  always @(posedge clk) begin
    p2[0] <= (mem_en && !mem_we) ? memval(mem_addr) : 32'h0;
    p2[1] <= p2[0];
    p1[0] <= (mem_en_1 && !mem_we_1) ? memval(mem_addr_1) : 32'h0;
    p4[0] <= (mem_en_4 && !mem_we_4) ? memval(mem_addr_4) : 32'h0;
    for (int i = 1; i < 4; i++) p4[i] <= p4[i-1];
  end
  assign mem_rdata   = p2[1];
  assign mem_rdata_1 = p1[0];
  assign mem_rdata_4 = p4[3];

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2)) dut (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .if_stall(if_stall), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .dm_stall(dm_stall), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata));

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_lat1 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_1),
    .if_ready(if_ready_1), .if_stall(if_stall_1), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata_1), .dm_ready(dm_ready_1),
    .dm_stall(dm_stall_1), .mem_en(mem_en_1), .mem_we(mem_we_1), .mem_addr(mem_addr_1),
    .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata_1));

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(4)) dut_lat4 (
    .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata_4),
    .if_ready(if_ready_4), .if_stall(if_stall_4), .dm_req(dm_req), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata_4), .dm_ready(dm_ready_4),
    .dm_stall(dm_stall_4), .mem_en(mem_en_4), .mem_we(mem_we_4), .mem_addr(mem_addr_4),
    .mem_wdata(mem_wdata_4), .mem_rdata(mem_rdata_4));

  // Advance one cycle; inputs and samples both land 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    if_req = 1; if_addr = 32'h4; rst = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_chk++;
      if ({mem_en, mem_we, if_ready, dm_ready} !== 4'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
          if_rdata !== '0 || dm_rdata !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: en=%b we=%b ir=%b dr=%b addr=%h wd=%h ird=%h drd=%h, required all 0",
                 mem_en, mem_we, if_ready, dm_ready, mem_addr, mem_wdata, if_rdata, dm_rdata);
      end
    end
    // Reset during ISSUE must drop mem_en asynchronously.
    rst = 0;
    step();
    n_chk++;
    if (mem_en !== 1'b1) begin n_fail++; $display("FAIL rst_issue_setup: mem_en=%b required 1", mem_en); end
    rst = 1;
    #1;
    n_chk++;
    if (mem_en !== 1'b0) begin n_fail++; $display("FAIL rst_issue_drop: mem_en=%b required 0", mem_en); end
    if_req = 0;
    step();
    rst = 0;
    // Reset during WAIT aborts the read: no ready afterwards.
    if_req = 1; if_addr = 32'h4;
    step();
    step();
    rst = 1;
    #1;
    n_chk++;
    if (mem_en !== 1'b0 || if_ready !== 1'b0) begin
      n_fail++; $display("FAIL rst_wait: mem_en=%b if_ready=%b required 0 0", mem_en, if_ready);
    end
    if_req = 0;
    step();
    rst = 0;
    for (int c = 0; c < 6; c++) begin
      step();
      n_chk++;
      if (if_ready !== 1'b0 || dm_ready !== 1'b0 || mem_en !== 1'b0) begin
        n_fail++;
        $display("FAIL no_ready_after_abort: cycle %0d ir=%b dr=%b en=%b required 0 0 0", c, if_ready, dm_ready, mem_en);
      end
    end
  endtask

  task automatic test_single_fetch();
    int n_en;
    apply_reset();
    n_en = 0;
    if_req = 1; if_addr = 32'h4;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (mem_en) begin
        n_en++;
        n_chk++;
        if (c != 1 || mem_addr !== 32'h4 || mem_we !== 1'b0) begin
          n_fail++; $display("FAIL fetch_issue: cycle %0d addr=%h we=%b, required cycle 1 addr 4 we 0", c, mem_addr, mem_we);
        end
      end
      n_chk++;
      if (if_ready !== (c == 4) || dm_ready !== 1'b0) begin
        n_fail++; $display("FAIL fetch_ready: cycle %0d if_ready=%b dm_ready=%b, required %b 0", c, if_ready, dm_ready, c == 4);
      end
      if (c == 4) begin
        n_chk++;
        if (if_rdata !== 32'h0050_0113) begin
          n_fail++; $display("FAIL fetch_data: got %h required 00500113", if_rdata);
        end
        if_req = 0;
      end
    end
    n_chk++;
    if (n_en != 1) begin n_fail++; $display("FAIL fetch_en_count: got %0d required 1", n_en); end
  endtask

  // Both request in C0; first winner ready in C4, second granted C5 (mem_en C6) and ready C9.
  task automatic tie_round(input bit if_first, input logic [31:0] ia, input logic [31:0] da);
    int if_c, dm_c, n_en;
    if_c = 0; dm_c = 0; n_en = 0;
    if_req = 1; if_addr = ia; dm_req = 1; dm_we = 0; dm_addr = da;
    for (int c = 1; c <= 12; c++) begin
      step();
      if (mem_en) begin
        n_en++;
        n_chk++;
        if (!((c == 1 && mem_addr === (if_first ? ia : da)) || (c == 6 && mem_addr === (if_first ? da : ia)))) begin
          n_fail++; $display("FAIL tie_mem_en: cycle %0d addr=%h unexpected", c, mem_addr);
        end
      end
      if (if_ready) begin
        if_c = c;
        n_chk++;
        if (if_rdata !== memval(ia)) begin n_fail++; $display("FAIL tie_if_data: got %h required %h", if_rdata, memval(ia)); end
        if_req = 0;
      end
      if (dm_ready) begin
        dm_c = c;
        n_chk++;
        if (dm_rdata !== memval(da)) begin n_fail++; $display("FAIL tie_dm_data: got %h required %h", dm_rdata, memval(da)); end
        dm_req = 0;
      end
    end
    n_chk++;
    if (if_c != (if_first ? 4 : 9) || dm_c != (if_first ? 9 : 4) || n_en != 2) begin
      n_fail++;
      $display("FAIL tie_order: if_ready C%0d dm_ready C%0d mem_en count %0d, required C%0d C%0d 2",
               if_c, dm_c, n_en, if_first ? 4 : 9, if_first ? 9 : 4);
    end
  endtask

  task automatic test_contention();
    bit got;
    apply_reset();
    tie_round(1'b1, 32'h8, 32'h200);
    // An IF-only access makes IF the last owner, so the next tie must go to DM.
    got = 0;
    if_req = 1; if_addr = 32'hC;
    for (int c = 1; c <= 8; c++) begin
      step();
      if (if_ready) begin got = 1; if_req = 0; break; end
    end
    n_chk++;
    if (!got) begin n_fail++; $display("FAIL solo_fetch: if_ready=0 required a pulse"); end
    step();
    tie_round(1'b0, 32'h8, 32'h204);
  endtask

  task automatic test_store();
    logic [31:0] prev;
    idle_inputs();
    prev = dm_rdata;
    dm_req = 1; dm_we = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    step();
    n_chk++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF || dm_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL store_issue: en=%b we=%b addr=%h wd=%h dr=%b, required 1 1 100 deadbeef 0", mem_en, mem_we, mem_addr, mem_wdata, dm_ready);
    end
    step();
    n_chk++;
    if (dm_ready !== 1'b1 || dm_rdata !== prev || mem_en !== 1'b0 || mem_we !== 1'b0 || if_ready !== 1'b0 || mem_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL store_resp: dr=%b drd=%h en=%b we=%b ir=%b addr=%h, required 1 %h 0 0 0 100",
               dm_ready, dm_rdata, mem_en, mem_we, if_ready, mem_addr, prev);
    end
    dm_req = 0; dm_we = 0;
    step();
    n_chk++;
    if (dm_ready !== 1'b0 || mem_en !== 1'b0) begin
      n_fail++; $display("FAIL store_done: dr=%b en=%b required 0 0", dm_ready, mem_en);
    end
  endtask

  task automatic test_input_change();
    int n_en;
    idle_inputs();
    n_en = 0;
    if_req = 1; if_addr = 32'h8;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (mem_en) n_en++;
      if (c <= 4) begin
        n_chk++;
        if (mem_addr !== 32'h8) begin n_fail++; $display("FAIL change_addr: cycle %0d mem_addr=%h required 8", c, mem_addr); end
      end
      if (c == 2) if_addr = 32'hC;
      if (c == 4) begin
        n_chk++;
        if (if_ready !== 1'b1 || if_rdata !== memval(32'h8)) begin
          n_fail++; $display("FAIL change_data: ready=%b data=%h required 1 %h", if_ready, if_rdata, memval(32'h8));
        end
        if_req = 0;
      end
    end
    n_chk++;
    if (n_en != 1) begin n_fail++; $display("FAIL change_en_count: got %0d required 1", n_en); end
  endtask

  task automatic test_latency_sweep();
    apply_reset();
    if_req = 1; if_addr = 32'h10;
    #1;
    n_chk++;
    if (if_stall_1 !== 1'b1 || if_stall_4 !== 1'b1) begin
      n_fail++; $display("FAIL sweep_stall_c0: lat1=%b lat4=%b required 1 1", if_stall_1, if_stall_4);
    end
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c <= 3) begin
        n_chk++;
        if (if_ready_1 !== (c == 3) || if_stall_1 !== (c < 3)) begin
          n_fail++; $display("FAIL sweep_lat1: cycle %0d ready=%b stall=%b required %b %b", c, if_ready_1, if_stall_1, c == 3, c < 3);
        end
      end
      if (c == 3) begin
        n_chk++;
        if (if_rdata_1 !== memval(32'h10)) begin n_fail++; $display("FAIL sweep_lat1_data: got %h required %h", if_rdata_1, memval(32'h10)); end
      end
      n_chk++;
      if (if_ready_4 !== (c == 6) || if_stall_4 !== (c < 6)) begin
        n_fail++; $display("FAIL sweep_lat4: cycle %0d ready=%b stall=%b required %b %b", c, if_ready_4, if_stall_4, c == 6, c < 6);
      end
    end
    n_chk++;
    if (if_rdata_4 !== memval(32'h10)) begin n_fail++; $display("FAIL sweep_lat4_data: got %h required %h", if_rdata_4, memval(32'h10)); end
    if_req = 0;
    for (int c = 0; c < 8; c++) step();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_store();
    test_input_change();
    test_latency_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
